calc_datapath_w: RTL

- Parametrised-width successor of the 4-bit calculator datapath.
- Holds two operand registers and one start/done-handshaked execution unit covering ALU ops, a sequential shift-add multiplier and a sequential restoring divider.
- Result registers feed a 4-way output select.
- Sits under the calculator control FSM, which drives load enables, go, op and the output select.

---
 rtl/calc_datapath_w.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/calc_datapath_w.sv
// W-bit calculator datapath: operand regs, ALU/shift-add multiplier/restoring divider, 4-way output mux.
// Latency: ALU and error paths 1 cycle after go, mul/div W cycles; go is ignored while busy.
module calc_datapath_w #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   input  logic         en_x,
   input  logic         en_y,
   input  logic         go,
   input  logic [2:0]   op,
   input  logic [1:0]   sel_out,
   output logic [W-1:0] out_h,
   output logic [W-1:0] out_l,
   output logic         busy,
   output logic         done,
   output logic         err
);
   localparam int CW = $clog2(W);

   typedef enum logic [1:0] {S_IDLE, S_ALU, S_MUL, S_DIV} state_t;

   state_t         state;
   logic [W-1:0]   a_q, b_q, wa, wb, res_h, res_l, quo, rem;
   logic [2:0]     wop;
   logic [CW-1:0]  cnt;
   logic [2*W-1:0] acc, acc_nxt;
   logic           busy_q, done_q, err_q;

   logic [W-1:0]   alu_h, alu_l;
   logic           alu_err;
   logic [W:0]     sum, diff, trial, trial_sub;
   logic           q_bit;
   logic [W-1:0]   rem_nxt, quo_nxt;

   // One MSB-first iteration of each sequential unit, indexed by cnt.
   always_comb begin
      acc_nxt   = {acc[2*W-2:0], 1'b0} + (wb[cnt] ? {{W{1'b0}}, wa} : {2*W{1'b0}});
      trial     = {rem, wa[cnt]};
      trial_sub = trial - {1'b0, wb};
      q_bit     = (trial >= {1'b0, wb});
      rem_nxt   = q_bit ? trial_sub[W-1:0] : trial[W-1:0];
      quo_nxt   = {quo[W-2:0], q_bit};
   end

   // Single-cycle results; div reaches here only with a zero divisor.
   always_comb begin
      sum     = {1'b0, wa} + {1'b0, wb};
      diff    = {1'b0, wa} - {1'b0, wb};
      alu_h   = '0;
      alu_l   = '0;
      alu_err = 1'b0;
      case (wop)
         3'b000: begin
            alu_l = sum[W-1:0];
            alu_h = {{(W-1){1'b0}}, sum[W]};
         end
         3'b001: begin
            alu_l = diff[W-1:0];
            alu_h = diff[W] ? '1 : '0;
         end
         3'b010: alu_l = wa & wb;
         3'b011: alu_l = wa | wb;
         3'b101: begin
            alu_l   = '1;
            alu_h   = wa;
            alu_err = 1'b1;
         end
         default: alu_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_IDLE;
         a_q    <= '0;
         b_q    <= '0;
         wa     <= '0;
         wb     <= '0;
         wop    <= '0;
         cnt    <= '0;
         acc    <= '0;
         quo    <= '0;
         rem    <= '0;
         res_h  <= '0;
         res_l  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (en_x) a_q <= x;
         if (en_y) b_q <= y;
         case (state)
            S_IDLE: begin
               if (go) begin
                  wa     <= a_q;
                  wb     <= b_q;
                  wop    <= op;
                  cnt    <= CW'(W-1);
                  acc    <= '0;
                  quo    <= '0;
                  rem    <= '0;
                  busy_q <= 1'b1;
                  if (op == 3'b100)
                     state <= S_MUL;
                  else if (op == 3'b101 && b_q != '0)
                     state <= S_DIV;
                  else
                     state <= S_ALU;
               end
            end
            S_ALU: begin
               res_h  <= alu_h;
               res_l  <= alu_l;
               err_q  <= alu_err;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            S_MUL: begin
               acc <= acc_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  {res_h, res_l} <= acc_nxt;
                  err_q  <= 1'b0;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            S_DIV: begin
               rem <= rem_nxt;
               quo <= quo_nxt;
               cnt <= cnt - CW'(1);
               if (cnt == '0) begin
                  res_h  <= rem_nxt;
                  res_l  <= quo_nxt;
                  err_q  <= 1'b0;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_comb begin
      case (sel_out)
         2'b01:   {out_h, out_l} = {res_h, res_l};
         2'b10:   {out_h, out_l} = {{W{1'b0}}, a_q};
         2'b11:   {out_h, out_l} = {{W{1'b0}}, b_q};
         default: {out_h, out_l} = '0;
      endcase
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule
